mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Sequences the single data-memory port (memory map + RAM/UART) between issued loads and ROB-retired stores.
// Retired stores enter a small in-order store buffer and drain when the port is free.
// Loads have priority, read through the buffer via store-to-load forwarding, and return on a registered
// response for the CDB submit path. A starvation counter guarantees forward progress of the store drain.
// PARAMETERS
// SB_DEPTH      4   store-buffer entries; power of 2, >=2
// ADDR_W        32  byte address width
// DATA_W        32  word width (full-word accesses only)
// TAG_W         6   ROB/rd tag width
// STARVE_LIMIT  3   consecutive load grants allowed while buffer non-empty before a forced drain; >=1
// PORTS
// clk             in   1              clock, rising edge
// rst             in   1              asynchronous reset, active-high
// flush           in   1              pipeline flush (mispredict)
// st_ret_valid    in   1              retired store offered
// st_ret_addr     in   ADDR_W         store address (rs1+imm)
// st_ret_data     in   DATA_W         store data (rs2)
// st_ret_ready    out  1              buffer can accept; = (sb_count < SB_DEPTH)
// ld_req_valid    in   1              load issued by memory issue queue
// ld_req_addr     in   ADDR_W         load address
// ld_req_tag      in   TAG_W          destination tag
// ld_req_ready    out  1              load granted this cycle if valid
// mem_we          out  1              memory write strobe
// mem_re          out  1              memory read strobe
// mem_addr        out  ADDR_W         memory address
// mem_wd          out  DATA_W         memory write data
// mem_rd          in   DATA_W         memory read data, combinational from mem_addr
// ld_resp_valid   out  1              load result valid
// ld_resp_tag     out  TAG_W          load result tag
// ld_resp_data    out  DATA_W         load result data
// sb_count        out  $clog2(SB_DEPTH+1)  occupied entries
// sb_empty        out  1              sb_count==0
// BEHAVIOUR
// - Reset (async, rst=1): buffer empty, pointers=0, starve_cnt=0, ld_resp_valid=0, ld_resp_tag=0,
//   ld_resp_data=0; combinationally mem_we=mem_re=0, mem_addr=mem_wd=0, st_ret_ready=1, sb_empty=1.
// - Exactly one port access per cycle. Grant decision (combinational, from registered state + inputs):
//   force_st = !sb_empty && (starve_cnt==STARVE_LIMIT). GNT_LD if ld_req_valid && !force_st;
//   else GNT_ST if !sb_empty; else GNT_NONE.
// - ld_req_ready = !force_st (independent of ld_req_valid).
// - GNT_LD: mem_re=1, mem_addr=ld_req_addr. GNT_ST: mem_we=1, mem_addr/mem_wd = head entry; head pops at edge.
//   GNT_NONE: all mem outputs 0.
// - starve_cnt: GNT_LD with buffer non-empty -> +1 (saturates at STARVE_LIMIT); GNT_ST or empty buffer -> 0.
// - Enqueue: st_ret_valid && st_ret_ready writes tail, tail+1 mod SB_DEPTH. Enqueue and pop in the same
//   cycle: count unchanged. Full buffer: st_ret_ready=0 even if a pop occurs that cycle (no bypass to full).
// - Forwarding on GNT_LD: compare ld_req_addr to all valid entries plus the same-cycle enqueue; the youngest
//   match wins (same-cycle enqueue is youngest); an entry popping this cycle still participates.
//   No match -> mem_rd.
// - Response latency 1: at the edge after GNT_LD, ld_resp_valid=1 with the tag and selected data;
//   otherwise ld_resp_valid=0 (tag/data hold).
// - flush: GNT_LD suppressed that cycle (ld_req_ready=0, mem_re=0); ld_resp_valid cleared next cycle.
//   Store buffer, drain, enqueue and starve_cnt unaffected: retired stores are committed.
// - Address compare on full ADDR_W; no byte/half support, no alignment check.
// - Reset mid-drain: buffered stores discarded; no partial write is emitted after rst asserts.
// TESTING
// - Reset, then load 0x40 (tag 5) with mem_rd=0xDEAD_BEEF -> next cycle ld_resp_valid=1, tag 5, data 0xDEADBEEF.
// - Enqueue 4 stores (0x10..0x1C) with continuous loads -> st_ret_ready=0 at count 4; after 3 load grants,
//   ld_req_ready=0 and mem_we=1 with addr 0x10.
// - Store 0x20=0x11 then 0x20=0x22 buffered, load 0x20 -> data 0x22, mem_rd ignored.
// - Store 0x30=0x55 enqueued the same cycle as load 0x30 -> response 0x55.
// - flush with ld_req_valid=1 and one buffered store -> mem_re=0, no response; store still drains (mem_we=1, addr).
// - rst asserted with 2 buffered stores -> sb_empty=1 immediately; no mem_we afterward.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the store-retire, load-request, memory-port and load-response
// signals shared by the data-memory port arbiter and whoever drives it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  // retired-store channel
  logic              st_ret_valid;
  logic [ADDR_W-1:0] st_ret_addr;
  logic [DATA_W-1:0] st_ret_data;
  logic              st_ret_ready;
  // issued-load channel
  logic              ld_req_valid;
  logic [ADDR_W-1:0] ld_req_addr;
  logic [TAG_W-1:0]  ld_req_tag;
  logic              ld_req_ready;
  // single data-memory port
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  // registered load response towards the CDB
  logic              ld_resp_valid;
  logic [TAG_W-1:0]  ld_resp_tag;
  logic [DATA_W-1:0] ld_resp_data;

  // arbiter side
  modport slave (
    input  st_ret_valid, st_ret_addr, st_ret_data,
    output st_ret_ready,
    input  ld_req_valid, ld_req_addr, ld_req_tag,
    output ld_req_ready,
    output mem_we, mem_re, mem_addr, mem_wd,
    input  mem_rd,
    output ld_resp_valid, ld_resp_tag, ld_resp_data
  );

  // pipeline / memory side
  modport master (
    output st_ret_valid, st_ret_addr, st_ret_data,
    input  st_ret_ready,
    output ld_req_valid, ld_req_addr, ld_req_tag,
    input  ld_req_ready,
    input  mem_we, mem_re, mem_addr, mem_wd,
    output mem_rd,
    input  ld_resp_valid, ld_resp_tag, ld_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: loads get the port first and see buffered stores
// through forwarding; retired stores wait in an in-order buffer and drain on
// idle cycles, with a starvation counter forcing a drain after a run of loads.
module mem_port_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 6,
  parameter int STARVE_LIMIT = 3,
  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1,
  localparam int CNT_W = $clog2(SB_DEPTH + 1),
  localparam int SV_W  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_empty
);

  // port grant encoding, decided fresh every cycle
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_LD   = 2'd1;
  localparam logic [1:0] GNT_ST   = 2'd2;

  // store buffer storage (no reset needed: occupancy lives in count_q)
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SV_W-1:0]   starve_q, starve_d;
  logic              resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic              empty, full, force_st, ld_ready, enq, pop;
  logic [1:0]        grant;
  logic [DATA_W-1:0] ld_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(SB_DEPTH));
  assign force_st = !empty && (starve_q == SV_W'(STARVE_LIMIT));
  // a flush kills the load slot; the store drain is unaffected
  assign ld_ready = !force_st && !flush;
  // no bypass into a full buffer even when the head pops this cycle
  assign enq      = bus.st_ret_valid && !full;
  assign pop      = (grant == GNT_ST);

  // pick the single port user for this cycle
  always_comb begin
    grant = GNT_NONE;
    if (bus.ld_req_valid && ld_ready) begin
      grant = GNT_LD;
    end else if (!empty) begin
      grant = GNT_ST;
    end
  end

  // drive the memory port from the grant
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    if (grant == GNT_LD) begin
      bus.mem_re   = 1'b1;
      bus.mem_addr = bus.ld_req_addr;
    end else if (grant == GNT_ST) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = sb_addr_q[head_q];
      bus.mem_wd   = sb_data_q[head_q];
    end
  end

  // store-to-load forwarding: scan oldest to youngest so the youngest match
  // wins; the head still counts while popping, and the same-cycle enqueue
  // is younger than everything in the buffer
  always_comb begin
    ld_data = bus.mem_rd;
    fwd_idx = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sb_addr_q[fwd_idx] == bus.ld_req_addr)) begin
        ld_data = sb_data_q[fwd_idx];
      end
    end
    if (enq && (bus.st_ret_addr == bus.ld_req_addr)) begin
      ld_data = bus.st_ret_data;
    end
  end

  // next-state for pointers, occupancy and the starvation counter
  always_comb begin
    head_d   = pop ? head_q + PTR_W'(1) : head_q;
    tail_d   = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d  = count_q;
    if (enq && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if ((grant == GNT_LD) && (starve_q != SV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SV_W'(1);
    end
  end

  // next-state for the registered load response; tag/data hold when idle
  always_comb begin
    resp_valid_d = (grant == GNT_LD);
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    if (grant == GNT_LD) begin
      resp_tag_d  = bus.ld_req_tag;
      resp_data_d = ld_data;
    end
  end

  // control state; reset discards any buffered stores at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // store buffer write at the tail
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_q[tail_q] <= bus.st_ret_addr;
      sb_data_q[tail_q] <= bus.st_ret_data;
    end
  end

  assign bus.st_ret_ready  = !full;
  assign bus.ld_req_ready  = ld_ready;
  assign bus.ld_resp_valid = resp_valid_q;
  assign bus.ld_resp_tag   = resp_tag_q;
  assign bus.ld_resp_data  = resp_data_q;
  assign sb_count          = count_q;
  assign sb_empty          = empty;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a queue-based
// model of the store buffer, grant priority, forwarding and starvation rule.
module tb_mem_port_arbiter;
  localparam int LIMIT = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] sb_count;
  logic       sb_empty;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(6)) bus ();

  mem_port_arbiter #(
    .SB_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .TAG_W(6), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // memory contents: a fixed hash, with one overridable word
  logic        rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr_addr = 32'h0;
  logic [31:0] rd_ovr_data = 32'h0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.mem_rd = (rd_ovr_en && bus.mem_addr == rd_ovr_addr) ? rd_ovr_data : hash(bus.mem_addr);

  // reference model
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;
  st_t         sbq[$];
  int          starve = 0;
  logic        m_rv = 1'b0;
  logic [5:0]  m_rt = '0;
  logic [31:0] m_rd = '0;

  int tests_run = 0;
  int errors = 0;

  // comb outputs sampled mid-cycle by the last call of run_cycle
  logic        obs_ld_rdy, obs_st_rdy, obs_we, obs_re;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    if (rd_ovr_en && a == rd_ovr_addr) return rd_ovr_data;
    return hash(a);
  endfunction

  // one clock of stimulus; entered and left at posedge+1
  task automatic run_cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                           input logic lv, input logic [31:0] la, input logic [5:0] lt,
                           input logic fl);
    logic        m_empty, force_st, ld_rdy, st_rdy, gld, gst, enq, hit;
    logic [31:0] e_addr, e_wd, ldat;
    bus.st_ret_valid = sv;
    bus.st_ret_addr  = sa;
    bus.st_ret_data  = sd;
    bus.ld_req_valid = lv;
    bus.ld_req_addr  = la;
    bus.ld_req_tag   = lt;
    flush            = fl;
    #4;
    m_empty  = (sbq.size() == 0);
    force_st = !m_empty && (starve == LIMIT);
    ld_rdy   = !force_st && !fl;
    gld      = lv && ld_rdy;
    gst      = !gld && !m_empty;
    st_rdy   = (sbq.size() < DEPTH);
    enq      = sv && st_rdy;
    e_addr   = gld ? la : (gst ? sbq[0].a : 32'h0);
    e_wd     = gst ? sbq[0].d : 32'h0;
    hit      = 1'b0;
    ldat     = model_mem(la);
    if (enq && sa == la) begin
      hit  = 1'b1;
      ldat = sd;
    end
    for (int i = sbq.size() - 1; i >= 0 && !hit; i--) begin
      if (sbq[i].a == la) begin
        hit  = 1'b1;
        ldat = sbq[i].d;
      end
    end
    obs_ld_rdy = bus.ld_req_ready;
    obs_st_rdy = bus.st_ret_ready;
    obs_we     = bus.mem_we;
    obs_re     = bus.mem_re;
    obs_addr   = bus.mem_addr;
    check("ld_req_ready", {31'b0, bus.ld_req_ready}, {31'b0, ld_rdy});
    check("st_ret_ready", {31'b0, bus.st_ret_ready}, {31'b0, st_rdy});
    check("mem_we", {31'b0, bus.mem_we}, {31'b0, gst});
    check("mem_re", {31'b0, bus.mem_re}, {31'b0, gld});
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wd", bus.mem_wd, e_wd);
    check("sb_count", {29'b0, sb_count}, sbq.size());
    check("sb_empty", {31'b0, sb_empty}, {31'b0, m_empty});
    if (gld || gst)
      $display("[TB] %0t %s addr=0x%08h data=0x%08h fwd=%0d cnt=%0d", $time,
               gld ? "LD" : "ST", e_addr, gld ? ldat : e_wd, hit, sbq.size());
    // advance the model
    if (gst) void'(sbq.pop_front());
    if (enq) sbq.push_back('{a: sa, d: sd});
    if (gst || m_empty) starve = 0;
    else if (gld && starve < LIMIT) starve++;
    m_rv = gld;
    if (gld) begin
      m_rt = lt;
      m_rd = ldat;
    end
    @(posedge clk);
    #1;
    check("ld_resp_valid", {31'b0, bus.ld_resp_valid}, {31'b0, m_rv});
    check("ld_resp_tag", {26'b0, bus.ld_resp_tag}, {26'b0, m_rt});
    check("ld_resp_data", bus.ld_resp_data, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0);
  endtask

  initial begin
    bus.st_ret_valid = 1'b0;
    bus.st_ret_addr  = '0;
    bus.st_ret_data  = '0;
    bus.ld_req_valid = 1'b0;
    bus.ld_req_addr  = '0;
    bus.ld_req_tag   = '0;
    #2;
    // reset state
    check("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_st_ready", {31'b0, bus.st_ret_ready}, 32'd1);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_resp_valid", {31'b0, bus.ld_resp_valid}, 32'd0);
    check("rst_resp_data", bus.ld_resp_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // load 0x40 tag 5 straight from memory
    rd_ovr_en   = 1'b1;
    rd_ovr_addr = 32'h40;
    rd_ovr_data = 32'hDEAD_BEEF;
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 6'd5, 1'b0);
    check("ld40_valid", {31'b0, bus.ld_resp_valid}, 32'd1);
    check("ld40_tag", {26'b0, bus.ld_resp_tag}, 32'd5);
    check("ld40_data", bus.ld_resp_data, 32'hDEAD_BEEF);

    // fill buffer under continuous loads until the forced drain
    for (int i = 0; i < 4; i++)
      run_cycle(1'b1, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 1'b1, 32'h80, 6'd1, 1'b0);
    run_cycle(1'b1, 32'h60, 32'h1, 1'b1, 32'h80, 6'd2, 1'b0);
    check("starve_ld_ready", {31'b0, obs_ld_rdy}, 32'd0);
    check("full_st_ready", {31'b0, obs_st_rdy}, 32'd0);
    check("starve_mem_we", {31'b0, obs_we}, 32'd1);
    check("starve_addr", obs_addr, 32'h10);
    idle(6);

    // youngest of two buffered stores to the same address wins
    run_cycle(1'b1, 32'h20, 32'h11, 1'b1, 32'h80, 6'd3, 1'b0);
    run_cycle(1'b1, 32'h20, 32'h22, 1'b1, 32'h84, 6'd4, 1'b0);
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 6'd6, 1'b0);
    check("fwd_young_data", bus.ld_resp_data, 32'h22);
    idle(4);

    // same-cycle enqueue forwards
    run_cycle(1'b1, 32'h30, 32'h55, 1'b1, 32'h30, 6'd7, 1'b0);
    check("fwd_enq_data", bus.ld_resp_data, 32'h55);
    idle(3);

    // flush suppresses the load but the store still drains
    run_cycle(1'b1, 32'h50, 32'h77, 1'b1, 32'h80, 6'd8, 1'b0);
    run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h84, 6'd9, 1'b1);
    check("flush_mem_re", {31'b0, obs_re}, 32'd0);
    check("flush_mem_we", {31'b0, obs_we}, 32'd1);
    check("flush_addr", obs_addr, 32'h50);
    check("flush_resp", {31'b0, bus.ld_resp_valid}, 32'd0);
    idle(2);
    rd_ovr_en = 1'b0;

    // randomized traffic over a small address window
    for (int n = 0; n < 400; n++) begin
      run_cycle(1'($urandom_range(0, 1)), {27'b0, 3'($urandom_range(0, 7)), 2'b00}, $urandom(),
                1'($urandom_range(0, 2) != 0), {27'b0, 3'($urandom_range(0, 7)), 2'b00},
                6'($urandom_range(0, 63)), 1'($urandom_range(0, 15) == 0));
    end
    idle(6);

    // reset with two buffered stores discards them immediately
    run_cycle(1'b1, 32'h70, 32'hA1, 1'b1, 32'h80, 6'd10, 1'b0);
    run_cycle(1'b1, 32'h74, 32'hA2, 1'b1, 32'h84, 6'd11, 1'b0);
    bus.st_ret_valid = 1'b0;
    bus.ld_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2_sb_empty", {31'b0, sb_empty}, 32'd1);
    check("rst2_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst2_resp_valid", {31'b0, bus.ld_resp_valid}, 32'd0);
    sbq.delete();
    starve = 0;
    m_rv = 1'b0;
    m_rt = '0;
    m_rd = '0;
    @(posedge clk);
    #1;
    check("rst2_hold_we", {31'b0, bus.mem_we}, 32'd0);
    rst = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
